// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: shifter type codes, instruction field
// positions and the immediate rotate-amount helper.
package arm_pkg;

  localparam logic [1:0] SFT_LSL = 2'b00;
  localparam logic [1:0] SFT_LSR = 2'b01;
  localparam logic [1:0] SFT_ASR = 2'b10;
  localparam logic [1:0] SFT_ROR = 2'b11;

  localparam int I_BIT      = 25;
  localparam int REG_AMT_BIT = 4;
  localparam int TYPE_LO    = 5;
  localparam int TYPE_HI    = 6;
  localparam int IMM_AMT_LO = 7;
  localparam int IMM_AMT_HI = 11;
  localparam int ROT_LO     = 8;
  localparam int ROT_HI     = 11;
  localparam int IMM8_HI    = 7;

  // AMT_IMM applies the instruction-encoded #0 aliases (LSR/ASR #32, RRX);
  // AMT_REG treats a zero amount as "no shift".
  typedef enum logic {
    AMT_IMM = 1'b0,
    AMT_REG = 1'b1
  } amt_mode_e;

  // The 4-bit rotate field encodes an even rotation of 0..30.
  function automatic logic [7:0] rot_amount(input logic [3:0] field);
    return {3'b000, field, 1'b0};
  endfunction

endpackage

// File: rtl/sft_core.sv
// Combinational 32-bit shifter: LSL/LSR/ASR/ROR/RRX with ARM carry-out rules
// for both instruction-encoded and register-supplied shift amounts.
module sft_core
  import arm_pkg::*;
(
  input  logic [31:0] val,
  input  logic [7:0]  amt,
  input  logic [1:0]  typ,
  input  logic        cin,
  input  amt_mode_e   mode,
  output logic [31:0] r,
  output logic        c
);

  logic [4:0]  sh_s;
  logic [32:0] lsl_s;
  logic [32:0] lsr_s;
  logic [32:0] asr_s;
  logic [31:0] ror_s;
  logic [31:0] std_r_s;
  logic        std_c_s;

  // 33-bit shifts carry the last bit shifted out in the extra position.
  assign sh_s  = amt[4:0];
  assign lsl_s = {1'b0, val} << sh_s;
  assign lsr_s = {val, 1'b0} >> sh_s;
  assign asr_s = 33'($signed({val, 1'b0}) >>> sh_s);
  assign ror_s = (val >> sh_s) | (val << (6'd32 - {1'b0, sh_s}));

  // Result of a plain shift by 1..31 positions.
  always_comb begin
    std_r_s = val;
    std_c_s = cin;
    case (typ)
      SFT_LSL: begin std_r_s = lsl_s[31:0];  std_c_s = lsl_s[32];  end
      SFT_LSR: begin std_r_s = lsr_s[32:1];  std_c_s = lsr_s[0];   end
      SFT_ASR: begin std_r_s = asr_s[32:1];  std_c_s = asr_s[0];   end
      SFT_ROR: begin std_r_s = ror_s;        std_c_s = ror_s[31];  end
      default: begin std_r_s = val;          std_c_s = cin;        end
    endcase
  end

  // Zero-amount and out-of-range amount handling around the plain shift.
  always_comb begin
    r = val;
    c = cin;
    if (mode == AMT_IMM) begin
      if (amt == 8'd0) begin
        case (typ)
          SFT_LSL: begin r = val;                c = cin;     end
          SFT_LSR: begin r = 32'h0;              c = val[31]; end
          SFT_ASR: begin r = {32{val[31]}};      c = val[31]; end
          SFT_ROR: begin r = {cin, val[31:1]};   c = val[0];  end
          default: begin r = val;                c = cin;     end
        endcase
      end else begin
        r = std_r_s;
        c = std_c_s;
      end
    end else begin
      if (amt == 8'd0) begin
        r = val;
        c = cin;
      end else if (amt[7:5] != 3'b000) begin
        case (typ)
          SFT_LSL: begin r = 32'h0; c = (amt == 8'd32) ? val[0]  : 1'b0; end
          SFT_LSR: begin r = 32'h0; c = (amt == 8'd32) ? val[31] : 1'b0; end
          SFT_ASR: begin r = {32{val[31]}}; c = val[31]; end
          SFT_ROR: begin
            if (sh_s == 5'd0) begin
              r = val;
              c = val[31];
            end else begin
              r = ror_s;
              c = ror_s[31];
            end
          end
          default: begin r = val; c = cin; end
        endcase
      end else begin
        r = std_r_s;
        c = std_c_s;
      end
    end
  end

endmodule

// File: rtl/sft_unit.sv
// Registered ARM operand-2 shifter: selects rotated immediate or shifted Rm
// and registers the operand and shifter carry-out for the ALU.
module sft_unit
  import arm_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INA,
  input  logic [31:0] INB,
  input  logic [31:0] OPCODE,
  input  logic        Cin,
  output logic [31:0] OUT,
  output logic        Cout
);

  logic [31:0] val_s;
  logic [7:0]  amt_s;
  logic [1:0]  typ_s;
  amt_mode_e   mode_s;
  logic [31:0] r_s;
  logic        c_s;
  logic [31:0] out_r;
  logic        cout_r;
  logic        unused_s;

  assign unused_s = ^{OPCODE[31:I_BIT+1], OPCODE[I_BIT-1:12], INB[31:8]};

  // The immediate path is a register-mode ROR of the zero-extended imm8, so a
  // zero rotation keeps Cin and a nonzero one yields r[31].
  always_comb begin
    if (OPCODE[I_BIT]) begin
      val_s  = {24'h0, OPCODE[IMM8_HI:0]};
      amt_s  = rot_amount(OPCODE[ROT_HI:ROT_LO]);
      typ_s  = SFT_ROR;
      mode_s = AMT_REG;
    end else if (OPCODE[REG_AMT_BIT]) begin
      val_s  = INA;
      amt_s  = INB[7:0];
      typ_s  = OPCODE[TYPE_HI:TYPE_LO];
      mode_s = AMT_REG;
    end else begin
      val_s  = INA;
      amt_s  = {3'b000, OPCODE[IMM_AMT_HI:IMM_AMT_LO]};
      typ_s  = OPCODE[TYPE_HI:TYPE_LO];
      mode_s = AMT_IMM;
    end
  end

  sft_core u_core (
    .val  (val_s),
    .amt  (amt_s),
    .typ  (typ_s),
    .cin  (Cin),
    .mode (mode_s),
    .r    (r_s),
    .c    (c_s)
  );

  // Output register, cleared asynchronously by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_r  <= 32'h0;
      cout_r <= 1'b0;
    end else begin
      out_r  <= r_s;
      cout_r <= c_s;
    end
  end

  assign OUT  = out_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_sft_unit.sv
// Self-checking bench for sft_unit: directed vectors plus randomized operands
// checked against a bit-serial shift reference model.
module tb_sft_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] INA;
  logic [31:0] INB;
  logic [31:0] OPCODE;
  logic        Cin;
  logic [31:0] OUT;
  logic        Cout;

  int n_cmp;
  int n_bad;

  sft_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .INA    (INA),
    .INB    (INB),
    .OPCODE (OPCODE),
    .Cin    (Cin),
    .OUT    (OUT),
    .Cout   (Cout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: shift one bit position at a time, remembering the last bit out.
  function automatic logic [32:0] ref_model(input logic [31:0] ina, input logic [31:0] inb,
                                            input logic [31:0] op, input logic cin);
    logic [31:0] v;
    logic        c;
    int          n;
    int          t;
    c = cin;
    if (op[25]) begin
      v = {24'h0, op[7:0]};
      n = 2 * int'(op[11:8]);
      for (int i = 0; i < n; i++) begin
        c = v[0];
        v = {v[0], v[31:1]};
      end
    end else begin
      v = ina;
      t = int'(op[6:5]);
      if (op[4]) begin
        n = int'(inb[7:0]);
      end else begin
        n = int'(op[11:7]);
        if (n == 0 && (t == 1 || t == 2)) n = 32;
      end
      if (!op[4] && n == 0 && t == 3) begin
        c = ina[0];
        v = {cin, ina[31:1]};
      end else begin
        for (int i = 0; i < n; i++) begin
          case (t)
            0:       begin c = v[31]; v = v << 1; end
            1:       begin c = v[0];  v = v >> 1; end
            2:       begin c = v[0];  v = {v[31], v[31:1]}; end
            default: begin c = v[0];  v = {v[0], v[31:1]}; end
          endcase
        end
      end
    end
    return {c, v};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] op, input logic ci);
    INA = a;
    INB = b;
    OPCODE = op;
    Cin = ci;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(32'hFFFFFFFF, 32'h0, 32'hE3A004FF, 1'b1);
    #3;
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: OUT=%h Cout=%b required OUT=00000000 Cout=0", OUT, Cout);
    end
    tick();
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: OUT=%h Cout=%b required OUT=00000000 Cout=0", OUT, Cout);
    end
    #2 RST = 1'b0;
  endtask

  task automatic test_immediate();
    drive(32'h50, 32'h10, 32'hE3A00050, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'h00000050 || Cout !== 1'b0) begin
      n_bad++;
      $display("FAIL imm_norot: OUT=%h Cout=%b required OUT=00000050 Cout=0", OUT, Cout);
    end
    drive(32'h50, 32'h10, 32'hE3A004FF, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'hFF000000 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL imm_rot8: OUT=%h Cout=%b required OUT=FF000000 Cout=1", OUT, Cout);
    end
    drive(32'h0, 32'h0, 32'hE3A000FF, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'h000000FF || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL imm_norot_cin: OUT=%h Cout=%b required OUT=000000FF Cout=1", OUT, Cout);
    end
  endtask

  task automatic test_shift_imm();
    drive(32'h40000001, 32'h0, 32'hE1A00100, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'h00000004 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL lsl2: OUT=%h Cout=%b required OUT=00000004 Cout=1", OUT, Cout);
    end
    drive(32'h80000000, 32'h0, 32'hE1A00020, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL lsr0: OUT=%h Cout=%b required OUT=00000000 Cout=1", OUT, Cout);
    end
    drive(32'h00000003, 32'h0, 32'hE1A00060, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'h80000001 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL rrx: OUT=%h Cout=%b required OUT=80000001 Cout=1", OUT, Cout);
    end
    drive(32'h12345678, 32'h0, 32'hE1A00000, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'h12345678 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL lsl0: OUT=%h Cout=%b required OUT=12345678 Cout=1", OUT, Cout);
    end
  endtask

  task automatic test_shift_reg();
    drive(32'h80000000, 32'h24, 32'hE1A00150, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'hFFFFFFFF || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL asr_reg36: OUT=%h Cout=%b required OUT=FFFFFFFF Cout=1", OUT, Cout);
    end
    drive(32'h80000000, 32'h0, 32'hE1A00150, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'h80000000 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL asr_reg0: OUT=%h Cout=%b required OUT=80000000 Cout=1", OUT, Cout);
    end
    drive(32'h00000001, 32'h20, 32'hE1A00110, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL lsl_reg32: OUT=%h Cout=%b required OUT=00000000 Cout=1", OUT, Cout);
    end
    drive(32'hFFFFFFFF, 32'h21, 32'hE1A00130, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b0) begin
      n_bad++;
      $display("FAIL lsr_reg33: OUT=%h Cout=%b required OUT=00000000 Cout=0", OUT, Cout);
    end
    drive(32'h80000001, 32'h40, 32'hE1A00170, 1'b0);
    tick();
    n_cmp++;
    if (OUT !== 32'h80000001 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL ror_reg64: OUT=%h Cout=%b required OUT=80000001 Cout=1", OUT, Cout);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op;
    logic        ci;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = $urandom;
      op = $urandom;
      ci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b[7:0] = 8'd32;
        1: b[7:0] = 8'd0;
        2: b[7:0] = 8'($urandom_range(1, 31));
        3: op[11:7] = 5'd0;
        default: ;
      endcase
      drive(a, b, op, ci);
      exp = ref_model(a, b, op, ci);
      tick();
      n_cmp++;
      if (OUT !== exp[31:0] || Cout !== exp[32]) begin
        n_bad++;
        $display("FAIL random[%0d]: op=%h ina=%h inb=%h cin=%b OUT=%h Cout=%b required OUT=%h Cout=%b",
                 i, op, a, b, ci, OUT, Cout, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    logic [32:0] exp_next;
    logic [31:0] a;
    logic [31:0] op;
    a = $urandom;
    op = {$urandom} & 32'hFDFFFFEF;
    drive(a, 32'h0, op, 1'b0);
    exp = ref_model(a, 32'h0, op, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      a = $urandom;
      op = $urandom;
      exp_next = ref_model(a, 32'h5, op, 1'b1);
      #2 drive(a, 32'h5, op, 1'b1);
      #1;
      n_cmp++;
      if (OUT !== exp[31:0] || Cout !== exp[32]) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: OUT=%h Cout=%b required OUT=%h Cout=%b",
                 i, OUT, Cout, exp[31:0], exp[32]);
      end
      exp = exp_next;
    end
    tick();
    n_cmp++;
    if (OUT !== exp[31:0] || Cout !== exp[32]) begin
      n_bad++;
      $display("FAIL back_to_back_last: OUT=%h Cout=%b required OUT=%h Cout=%b",
               OUT, Cout, exp[31:0], exp[32]);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h0, 32'h0, 32'hE3A004FF, 1'b1);
    tick();
    n_cmp++;
    if (OUT !== 32'hFF000000 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: OUT=%h Cout=%b required OUT=FF000000 Cout=1", OUT, Cout);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (OUT !== 32'h0 || Cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: OUT=%h Cout=%b required OUT=00000000 Cout=0", OUT, Cout);
    end
    #1 RST = 1'b0;
    tick();
    n_cmp++;
    if (OUT !== 32'hFF000000 || Cout !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset: OUT=%h Cout=%b required OUT=FF000000 Cout=1", OUT, Cout);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_immediate();
    test_shift_imm();
    test_shift_reg();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
